// File: rtl/seq_divider16.sv
// -----------------------------------------------------------------------------
// seq_divider16
//   Multi-cycle restoring divider, unsigned or two's-complement signed. It
//   produces one quotient bit per clock and sits beside the carry-select
//   add/sub unit in the arithmetic block.
//
//   Handshake (both sides): a transfer happens on the rising edge where
//   valid and ready are both high. in_ready is high only in IDLE; out_valid is
//   high only in DONE, and the result outputs are held stable until the
//   consumer raises out_ready. Inputs are sampled only on the accept edge.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake
//   dividend, divisor     operands, WIDTH bits
//   mod                   0 = unsigned, 1 = signed
//   out_valid / out_ready result handshake
//   quotient, remainder   registered results
//   div_by_zero           divisor was zero for this result
//   overflow              signed MIN / -1 for this result
//   dbg_state             current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
// -----------------------------------------------------------------------------
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;     // dividend magnitude; quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs;     // divisor magnitude
  logic [WIDTH-1:0] p;       // partial remainder
  logic             mode_q;
  logic             neg_a;
  logic             neg_b;
  logic             ovf_q;

  // The shifted partial remainder can need WIDTH+1 bits in unsigned mode
  // (divisor magnitude up to 2^WIDTH-1), so keep the bit that falls out of p.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  assign shifted = {p, dvd[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};

  assign abs_a = (mod && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b = (mod && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Sign fix-up. For MIN / -1 both signs are negative, so the unsigned
  // magnitude quotient (2^(WIDTH-1)) already reads as MIN with remainder 0.
  assign q_fix = (mode_q && (neg_a ^ neg_b)) ? -dvd : dvd;
  assign r_fix = (mode_q && neg_a) ? -p : p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      p           <= '0;
      mode_q      <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      ovf_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mode_q      <= mod;
            neg_a       <= mod & dividend[WIDTH-1];
            neg_b       <= mod & divisor[WIDTH-1];
            dvd         <= abs_a;
            dvs         <= abs_b;
            p           <= '0;
            cnt         <= CW'(WIDTH - 1);
            ovf_q       <= mod && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                               && (divisor == {WIDTH{1'b1}});
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!diff[WIDTH+1]) begin
            p   <= diff[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            p   <= shifted[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          overflow  <= ovf_q;
          state     <= S_DONE;
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// -----------------------------------------------------------------------------
// tb_seq_divider16
//   Directed and random stimulus for seq_divider16 (WIDTH=16). Expected
//   results come from plain integer division in ref_div and are queued in
//   exp_q when an operation is launched, then popped when its result appears.
// -----------------------------------------------------------------------------
module tb_seq_divider16;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         mod;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;
  logic [1:0]   dbg_state;

  // {overflow, div_by_zero, remainder, quotient}
  logic [2*W+1:0] exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  seq_divider16 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .mod        (mod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- reference
  function automatic logic [2*W+1:0] ref_div(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic m);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ov;
    int           sa;
    int           sb;
    int           qi;
    int           ri;
    ov = 1'b0;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!m) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
      ov = (a == 16'h8000) && (b == 16'hFFFF);
    end
    return {ov, (b == '0), r, q};
  endfunction

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [2*W+1:0] obs,
                       input logic [2*W+1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W+1:0] outs();
    return {overflow, div_by_zero, remainder, quotient};
  endfunction

  // ---------------------------------------------------------------- driver
  // Launches one operation, checks the accept-to-valid latency, the result,
  // that it stays stable for `hold` cycles of back-pressure (with a competing
  // in_valid present), and the return to IDLE after the output handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic m, input int hold);
    int n;
    int lat;
    logic [2*W+1:0] e;
    exp_q.push_back(ref_div(a, b, m));
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    mod       = m;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_timeout"}, (n < 100), 1'b1);
    @(posedge clk);                       // accept edge
    @(negedge clk);
    in_valid = 1'b0;
    dividend = W'($urandom);              // later input changes must not matter
    divisor  = W'($urandom);
    mod      = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, (b == '0) ? 1 : W + 2);
    e = exp_q.pop_front();
    check({tag, "_result"}, outs(), e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 16'h0001;
      divisor  = 16'h0001;
      @(negedge clk);
      check({tag, "_hold_result"}, outs(), e);
      check({tag, "_hold_flags"}, {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
    check({tag, "_kept_after_hs"}, outs(), e);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rm;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    mod       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), '0);
    check("reset_handshake", {out_valid, in_ready}, 2'b01);
    rst_n = 1'b1;

    // Directed cases.
    check("t1_model", ref_div(16'd100, 16'd7, 1'b0), {2'b00, 16'd2, 16'd14});
    run_op("t1_100_div_7", 16'd100, 16'd7, 1'b0, 0);
    run_op("t2_m7_div_2", 16'hFFF9, 16'h0002, 1'b1, 0);
    run_op("t2_7_div_m2", 16'h0007, 16'hFFFE, 1'b1, 0);
    run_op("t3_min_div_m1_s", 16'h8000, 16'hFFFF, 1'b1, 0);
    run_op("t3_min_div_m1_u", 16'h8000, 16'hFFFF, 1'b0, 0);
    run_op("t4_div_zero", 16'h1234, 16'h0000, 1'b0, 0);
    run_op("t4_div_zero_s", 16'h8765, 16'h0000, 1'b1, 0);
    run_op("ffff_div_1_u", 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op("big_divisor_u", 16'hFFFF, 16'h8001, 1'b0, 0);
    run_op("small_div_big", 16'h0003, 16'h0009, 1'b1, 0);
    run_op("t5_backpressure", 16'd1000, 16'd33, 1'b0, 5);

    // Reset in the middle of CALC: the op is discarded and outputs clear.
    @(negedge clk);
    dividend = 16'h1234;
    divisor  = 16'h0007;
    mod      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", outs(), '0);
    check("t6_reset_handshake", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t6_after_reset", 16'hFFFF, 16'h0003, 1'b0, 0);

    // Random operations with a bias towards the corner operands.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 16'hFFFF;
        2: ra = 16'h8000;
        3: rb = W'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", ra, rb, rm, $urandom_range(0, 2));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
